// File: rtl/latch_write_ctrl_pkg.sv
// Shared definitions for the latch write controller: FSM encodings and
// timing-parameter helpers used at elaboration.
package latch_write_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_OPEN  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_CHECK = 3'd4
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Every phase needs at least one cycle, otherwise the down-counter load of N-1 underflows.
  function automatic bit timing_ok(input int s, input int p, input int h);
    return (s >= 1) && (p >= 1) && (h >= 1);
  endfunction

endpackage

// File: rtl/latch_write_ctrl_phase_counter.sv
// Loadable down-counter with a zero flag; times each write phase.
module phase_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load)
      cnt_d = load_val;
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Write-side controller for a level-sensitive latch bank: drives d/en with a
// setup/pulse/hold window, then reads q back and flags a mismatch.
module latch_write_ctrl
  import latch_write_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] d,
  output logic             en,
  input  logic [WIDTH-1:0] q,
  output logic             done,
  output logic             err
);

  localparam int CNT_W = $clog2(max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);
  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  generate
    if (!timing_ok(SETUP_CYC, PULSE_CYC, HOLD_CYC)) begin : g_bad_timing
      $error("latch_write_ctrl: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end
  endgenerate

  state_e           state_q, state_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             en_q, en_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt_ld_val;

  phase_counter #(.W(CNT_W)) u_phase_counter (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign in_ready = (state_q == ST_IDLE) & ~rst;

  always_comb begin
    state_d    = state_q;
    d_d        = d_q;
    en_d       = en_q;
    done_d     = 1'b0;
    err_d      = err_q;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_ld_val = '0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          d_d        = in_data;
          err_d      = 1'b0;
          cnt_load   = 1'b1;
          cnt_ld_val = SETUP_LD;
          state_d    = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          en_d       = 1'b1;
          cnt_load   = 1'b1;
          cnt_ld_val = PULSE_LD;
          state_d    = ST_OPEN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_OPEN: begin
        if (cnt_zero) begin
          en_d       = 1'b0;
          cnt_load   = 1'b1;
          cnt_ld_val = HOLD_LD;
          state_d    = ST_HOLD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) state_d = ST_CHECK;
        else          cnt_dec = 1'b1;
      end
      ST_CHECK: begin
        // q has been stable for HOLD_CYC cycles by now; this is the only sample point.
        err_d   = (q != d_q);
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        en_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      d_q     <= '0;
      en_q    <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      en_q    <= en_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign d    = d_q;
  assign en   = en_q;
  assign done = done_q;
  assign err  = err_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// Directed bench for latch_write_ctrl: default-timing instance and a
// SETUP=3/PULSE=1/HOLD=4 instance, each driving a behavioural latch bank.
module tb_latch_write_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid_a, in_ready_a, en_a, done_a, err_a;
  logic [7:0] in_data_a, d_a, q_a, mask_a;
  logic       in_valid_b, in_ready_b, en_b, done_b, err_b;
  logic [7:0] in_data_b, d_b, q_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  latch_write_ctrl u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a),
    .in_data(in_data_a), .d(d_a), .en(en_a), .q(q_a), .done(done_a), .err(err_a)
  );

  latch_write_ctrl #(.WIDTH(8), .SETUP_CYC(3), .PULSE_CYC(1), .HOLD_CYC(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b),
    .in_data(in_data_b), .d(d_b), .en(en_b), .q(q_b), .done(done_b), .err(err_b)
  );

  // Behavioural latch banks; mask_a models stuck-at-0 bits.
  always @(d_a or en_a or mask_a) if (en_a) q_a = d_a & mask_a;
  always @(d_b or en_b) if (en_b) q_b = d_b;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready_a); end
    total++; if (en_a !== 1'b0) begin bad++; $display("FAIL reset_en got=%b exp=0", en_a); end
    total++; if (d_a !== 8'h00) begin bad++; $display("FAIL reset_d got=%h exp=00", d_a); end
    total++; if (done_a !== 1'b0 || err_a !== 1'b0) begin bad++; $display("FAIL reset_done_err got=%b%b exp=00", done_a, err_a); end
    rst = 1'b0;
    #1;
    total++; if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b%b exp=11", in_ready_a, in_ready_b); end
  endtask

  task automatic test_single_write();
    in_valid_a = 1'b1; in_data_a = 8'hA5;
    step();
    in_valid_a = 1'b0; in_data_a = 8'h00;
    for (int k = 0; k <= 7; k++) begin
      if (k > 0) step();
      total++; if (en_a !== (k == 1 || k == 2)) begin bad++; $display("FAIL single_en k=%0d got=%b exp=%b", k, en_a, (k == 1 || k == 2)); end
      total++; if (done_a !== (k == 5)) begin bad++; $display("FAIL single_done k=%0d got=%b exp=%b", k, done_a, (k == 5)); end
      total++; if (in_ready_a !== (k >= 5)) begin bad++; $display("FAIL single_ready k=%0d got=%b exp=%b", k, in_ready_a, (k >= 5)); end
      total++; if (d_a !== 8'hA5) begin bad++; $display("FAIL single_d k=%0d got=%h exp=a5", k, d_a); end
    end
    total++; if (q_a !== 8'hA5) begin bad++; $display("FAIL single_q got=%h exp=a5", q_a); end
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err_a); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] prev_d;
    int dones;
    dones = 0;
    in_valid_a = 1'b1; in_data_a = 8'h3C;
    step();
    in_data_a = 8'hC3;
    prev_d = d_a;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) step();
      if (k == 6) in_valid_a = 1'b0;
      if (done_a) dones++;
      total++; if (en_a && d_a !== prev_d) begin bad++; $display("FAIL b2b_d_while_en k=%0d got=%h exp=%h", k, d_a, prev_d); end
      prev_d = d_a;
      total++; if (d_a !== ((k < 6) ? 8'h3C : 8'hC3)) begin bad++; $display("FAIL b2b_d k=%0d got=%h exp=%h", k, d_a, (k < 6) ? 8'h3C : 8'hC3); end
      total++; if (done_a !== (k == 5 || k == 11)) begin bad++; $display("FAIL b2b_done k=%0d got=%b exp=%b", k, done_a, (k == 5 || k == 11)); end
    end
    total++; if (dones != 2) begin bad++; $display("FAIL b2b_done_count got=%0d exp=2", dones); end
    total++; if (err_a !== 1'b0 || q_a !== 8'hC3) begin bad++; $display("FAIL b2b_final got err=%b q=%h exp err=0 q=c3", err_a, q_a); end
  endtask

  task automatic test_stuck_bit();
    mask_a = 8'h7F;
    in_valid_a = 1'b1; in_data_a = 8'hFF;
    step();
    in_valid_a = 1'b0;
    for (int k = 1; k <= 5; k++) step();
    total++; if (done_a !== 1'b1 || err_a !== 1'b1) begin bad++; $display("FAIL stuck_done_err got=%b%b exp=11", done_a, err_a); end
    total++; if (q_a !== 8'h7F) begin bad++; $display("FAIL stuck_q got=%h exp=7f", q_a); end
    for (int k = 0; k < 3; k++) step();
    total++; if (err_a !== 1'b1) begin bad++; $display("FAIL stuck_err_sticky got=%b exp=1", err_a); end
    mask_a = 8'hFF;
    in_valid_a = 1'b1; in_data_a = 8'h00;
    step();
    in_valid_a = 1'b0;
    total++; if (err_a !== 1'b0) begin bad++; $display("FAIL stuck_err_clear got=%b exp=0", err_a); end
    for (int k = 1; k <= 5; k++) step();
    total++; if (done_a !== 1'b1 || err_a !== 1'b0) begin bad++; $display("FAIL stuck_rewrite got=%b%b exp=10", done_a, err_a); end
  endtask

  task automatic test_reset_mid_open();
    in_valid_a = 1'b1; in_data_a = 8'h55;
    step();
    in_valid_a = 1'b0;
    step();
    total++; if (en_a !== 1'b1) begin bad++; $display("FAIL rstmid_open_en got=%b exp=1", en_a); end
    rst = 1'b1;
    #1;
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL rstmid_ready_during got=%b exp=0", in_ready_a); end
    step();
    total++; if (en_a !== 1'b0 || d_a !== 8'h00) begin bad++; $display("FAIL rstmid_en_d got en=%b d=%h exp en=0 d=00", en_a, d_a); end
    total++; if (in_ready_a !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b exp=0", in_ready_a); end
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      total++; if (done_a !== 1'b0 || en_a !== 1'b0) begin bad++; $display("FAIL rstmid_quiet k=%0d got done=%b en=%b exp 0 0", k, done_a, en_a); end
    end
    total++; if (in_ready_a !== 1'b1 || err_a !== 1'b0) begin bad++; $display("FAIL rstmid_idle got ready=%b err=%b exp 1 0", in_ready_a, err_a); end
  endtask

  task automatic test_long_timing();
    in_valid_b = 1'b1; in_data_b = 8'h5A;
    step();
    in_valid_b = 1'b0;
    for (int k = 0; k <= 10; k++) begin
      if (k > 0) step();
      total++; if (en_b !== (k == 3)) begin bad++; $display("FAIL long_en k=%0d got=%b exp=%b", k, en_b, (k == 3)); end
      total++; if (done_b !== (k == 9)) begin bad++; $display("FAIL long_done k=%0d got=%b exp=%b", k, done_b, (k == 9)); end
      total++; if (in_ready_b !== (k >= 9)) begin bad++; $display("FAIL long_ready k=%0d got=%b exp=%b", k, in_ready_b, (k >= 9)); end
    end
    total++; if (q_b !== 8'h5A || err_b !== 1'b0) begin bad++; $display("FAIL long_final got q=%h err=%b exp q=5a err=0", q_b, err_b); end
  endtask

  task automatic test_busy_ignore();
    logic [7:0] pat;
    in_valid_a = 1'b1; in_data_a = 8'h11;
    step();
    for (int k = 0; k <= 5; k++) begin
      if (k > 0) step();
      pat = 8'hE0 + 8'(k);
      in_data_a  = pat;
      in_valid_a = (k < 5) ? ((k % 2) == 0) : 1'b0;
      total++; if (in_ready_a !== (k == 5)) begin bad++; $display("FAIL busy_ready k=%0d got=%b exp=%b", k, in_ready_a, (k == 5)); end
      total++; if (d_a !== 8'h11) begin bad++; $display("FAIL busy_d k=%0d got=%h exp=11", k, d_a); end
    end
    total++; if (done_a !== 1'b1 || err_a !== 1'b0) begin bad++; $display("FAIL busy_done got=%b%b exp=10", done_a, err_a); end
    step();
    total++; if (d_a !== 8'h11 || in_ready_a !== 1'b1) begin bad++; $display("FAIL busy_idle got d=%h ready=%b exp d=11 ready=1", d_a, in_ready_a); end
  endtask

  initial begin
    rst = 1'b1;
    in_valid_a = 1'b0; in_data_a = 8'h00; mask_a = 8'hFF;
    in_valid_b = 1'b0; in_data_b = 8'h00;
    #1;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_stuck_bit();
    test_reset_mid_open();
    test_long_timing();
    test_busy_ignore();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
